dmem_responder: RTL and testbench

Data-memory responder for the multicycle CPU's load/store port; it answers the CPU's `dmem_r`/`dmem_w` requests. It decodes the byte address and applies word/halfword/byte write masks from `store_format_signal`. It returns lane-aligned read data after a programmable number of wait states, signals completion with `ready`, and flags misaligned, out-of-range and conflicting requests on `addr_err`.

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_bank.sv | 27 ++
 rtl/dmem_responder.sv | 165 ++++++++++++++++
 tb/tb_dmem_responder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access formats, FSM states
// and the byte-enable mapping used by the write path.
package dmem_pkg;

    localparam logic [1:0] FMT_WORD = 2'b00;
    localparam logic [1:0] FMT_HALF = 2'b01;
    localparam logic [1:0] FMT_BYTE = 2'b10;
    localparam logic [1:0] FMT_RSVD = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Lane 0 is bits [7:0]; halfwords pick the pair selected by lane[1].
    function automatic logic [3:0] byte_enable(input logic [1:0] fmt, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (fmt)
            FMT_WORD: be = 4'b1111;
            FMT_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            FMT_BYTE: be = 4'b0001 << lane;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-enabled DEPTH_WORDS x 32 storage: synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_bank #(
    parameter int DEPTH_WORDS = 2048,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [3:0]       i_be,
    input  logic [IDX_W-1:0] i_idx,
    input  logic [31:0]      i_wdata,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) begin
                r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for the multicycle CPU: qualifies requests, inserts
// WAIT_CYCLES wait states, then commits a masked write or returns lane-aligned data.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 2048,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_addr,
    input  logic [31:0] w_data,
    input  logic        dmem_w,
    input  logic        dmem_r,
    input  logic [1:0]  store_format_signal,
    output logic [31:0] dmem_data,
    output logic        ready,
    output logic        addr_err
);

    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_cnt;
    logic               r_is_write;
    logic [IDX_W-1:0]   r_idx;
    logic [1:0]         r_lane;
    logic [1:0]         r_fmt;
    logic [31:0]        r_wdata;
    logic [31:0]        r_dmem_data;
    logic               r_addr_err;

    logic [31:0]        w_offset;
    logic               w_req;
    logic               w_misalign;
    logic               w_out_of_range;
    logic               w_bad;
    logic               w_accept;
    logic               w_reject;
    logic               w_commit;
    logic [31:0]        w_bank_rdata;
    logic [31:0]        w_bank_wdata;
    logic [31:0]        w_rd_shifted;
    logic [31:0]        w_rd_aligned;

    // Addresses below the base wrap to a huge offset and fail the range check.
    assign w_offset       = data_addr - ADDR_BASE;
    assign w_out_of_range = ({1'b0, w_offset} >= SPAN);
    assign w_req          = dmem_r | dmem_w;

    always_comb begin
        w_misalign = 1'b0;
        case (store_format_signal)
            FMT_WORD: w_misalign = (data_addr[1:0] != 2'b00);
            FMT_HALF: w_misalign = data_addr[0];
            default:  w_misalign = 1'b0;
        endcase
    end

    assign w_bad = (dmem_r & dmem_w) | (store_format_signal == FMT_RSVD)
                 | w_misalign | w_out_of_range;

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (w_bad) begin
                        w_reject = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_next_state = BUSY;
                    end
                end
            end
            BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_commit     = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt       <= 4'd0;
            r_is_write  <= 1'b0;
            r_idx       <= '0;
            r_lane      <= 2'b00;
            r_fmt       <= FMT_WORD;
            r_wdata     <= 32'h0;
            r_dmem_data <= 32'h0;
            r_addr_err  <= 1'b0;
        end else begin
            r_addr_err <= w_reject;
            if (w_accept) begin
                r_cnt      <= 4'(WAIT_CYCLES);
                r_is_write <= dmem_w;
                r_idx      <= w_offset[IDX_W+1:2];
                r_lane     <= data_addr[1:0];
                r_fmt      <= store_format_signal;
                r_wdata    <= w_data;
            end else if (r_state == BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && !r_is_write) begin
                r_dmem_data <= w_rd_aligned;
            end
        end
    end

    // Replicate narrow store data into every lane; byte enables pick the target.
    always_comb begin
        w_bank_wdata = r_wdata;
        case (r_fmt)
            FMT_HALF: w_bank_wdata = {2{r_wdata[15:0]}};
            FMT_BYTE: w_bank_wdata = {4{r_wdata[7:0]}};
            default:  w_bank_wdata = r_wdata;
        endcase
    end

    assign w_rd_shifted = w_bank_rdata >> {r_lane, 3'b000};

    always_comb begin
        w_rd_aligned = w_rd_shifted;
        case (r_fmt)
            FMT_HALF: w_rd_aligned = {16'h0, w_rd_shifted[15:0]};
            FMT_BYTE: w_rd_aligned = {24'h0, w_rd_shifted[7:0]};
            default:  w_rd_aligned = w_rd_shifted;
        endcase
    end

    dmem_bank #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk     (clk),
        .i_we    (w_commit & r_is_write),
        .i_be    (byte_enable(r_fmt, r_lane)),
        .i_idx   (r_idx),
        .i_wdata (w_bank_wdata),
        .o_rdata (w_bank_rdata)
    );

    assign dmem_data = r_dmem_data;
    assign ready     = (r_state == IDLE);
    assign addr_err  = r_addr_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (1, 0 and 5 wait states)
// share one request stream; expected values are hand-computed constants.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] dataAddr;
    logic [31:0] wData;
    logic        dmemW;
    logic        dmemR;
    logic [1:0]  storeFmt;

    logic [31:0] dataMain, data0, data5;
    logic        readyMain, ready0, ready5;
    logic        errMain, err0, err5;

    int nVec;
    int nFail;
    int lowMain, low0, low5;

    dmem_responder #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .data_addr(dataAddr), .w_data(wData),
        .dmem_w(dmemW), .dmem_r(dmemR), .store_format_signal(storeFmt),
        .dmem_data(dataMain), .ready(readyMain), .addr_err(errMain)
    );

    dmem_responder #(.WAIT_CYCLES(0)) dutW0 (
        .clk(clk), .rst(rst), .data_addr(dataAddr), .w_data(wData),
        .dmem_w(dmemW), .dmem_r(dmemR), .store_format_signal(storeFmt),
        .dmem_data(data0), .ready(ready0), .addr_err(err0)
    );

    dmem_responder #(.WAIT_CYCLES(5)) dutW5 (
        .clk(clk), .rst(rst), .data_addr(dataAddr), .w_data(wData),
        .dmem_w(dmemW), .dmem_r(dmemR), .store_format_signal(storeFmt),
        .dmem_data(data5), .ready(ready5), .addr_err(err5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle request pulse, then wait (bounded) until every instance is idle again.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [1:0] fmt,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit scramble);
        int cyc;
        @(negedge clk);
        dmemW    = wr;
        dmemR    = rd;
        storeFmt = fmt;
        dataAddr = addr;
        wData    = wdata;
        @(posedge clk);
        @(negedge clk);
        dmemW = 1'b0;
        dmemR = 1'b0;
        if (scramble) begin
            dataAddr = addr ^ 32'h4;
            wData    = ~wdata;
            storeFmt = FMT_BYTE;
        end
        lowMain = 0;
        low0    = 0;
        low5    = 0;
        cyc     = 0;
        while (!(readyMain && ready0 && ready5) && cyc < 50) begin
            if (!readyMain) lowMain++;
            if (!ready0)    low0++;
            if (!ready5)    low5++;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 50) checkOutput("ready_timeout", 32'(cyc), 32'd0);
    endtask

    task automatic readAll(input logic [1:0] fmt, input logic [31:0] addr,
                           input logic [31:0] exp, input string tag);
        applyStimulus(1'b0, 1'b1, fmt, addr, 32'h0, 1'b0);
        checkOutput({tag, "_w1"}, dataMain, exp);
        checkOutput({tag, "_w0"}, data0, exp);
        checkOutput({tag, "_w5"}, data5, exp);
    endtask

    // Rejected request: one-cycle addr_err pulse, ready held high, read data untouched.
    task automatic rejectReq(input logic wr, input logic rd, input logic [1:0] fmt,
                             input logic [31:0] addr, input logic [31:0] holdData,
                             input string tag);
        @(negedge clk);
        dmemW    = wr;
        dmemR    = rd;
        storeFmt = fmt;
        dataAddr = addr;
        wData    = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        dmemW = 1'b0;
        dmemR = 1'b0;
        checkOutput({tag, "_err_hi"}, 32'(errMain), 32'd1);
        checkOutput({tag, "_err5_hi"}, 32'(err5), 32'd1);
        checkOutput({tag, "_ready"}, 32'(readyMain), 32'd1);
        checkOutput({tag, "_data"}, dataMain, holdData);
        @(negedge clk);
        checkOutput({tag, "_err_lo"}, 32'(errMain), 32'd0);
        checkOutput({tag, "_ready2"}, 32'(readyMain && ready0 && ready5), 32'd1);
    endtask

    initial begin
        nVec     = 0;
        nFail    = 0;
        rst      = 1'b0;
        dataAddr = 32'h0;
        wData    = 32'h0;
        dmemW    = 1'b0;
        dmemR    = 1'b0;
        storeFmt = FMT_WORD;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(readyMain && ready0 && ready5), 32'd1);
        checkOutput("rst_data", dataMain, 32'h0);
        checkOutput("rst_err", 32'(errMain), 32'd0);
        rst = 1'b1;

        // Word round trip with wait-state sweep on the ready-low window.
        applyStimulus(1'b1, 1'b0, FMT_WORD, 32'h1001_0004, 32'hDEAD_BEEF, 1'b0);
        checkOutput("wr_low_w1", 32'(lowMain), 32'd2);
        checkOutput("wr_low_w0", 32'(low0), 32'd1);
        checkOutput("wr_low_w5", 32'(low5), 32'd6);
        checkOutput("wr_keeps_data", dataMain, 32'h0);
        applyStimulus(1'b0, 1'b1, FMT_WORD, 32'h1001_0004, 32'h0, 1'b0);
        checkOutput("rd_low_w1", 32'(lowMain), 32'd2);
        checkOutput("rd_low_w0", 32'(low0), 32'd1);
        checkOutput("rd_low_w5", 32'(low5), 32'd6);
        checkOutput("rd_word", dataMain, 32'hDEAD_BEEF);
        checkOutput("rd_word_w0", data0, 32'hDEAD_BEEF);
        checkOutput("rd_word_w5", data5, 32'hDEAD_BEEF);

        // Byte and halfword merges into one word.
        applyStimulus(1'b1, 1'b0, FMT_WORD, 32'h1001_0008, 32'h0000_0000, 1'b0);
        applyStimulus(1'b1, 1'b0, FMT_BYTE, 32'h1001_000A, 32'h0000_00AB, 1'b0);
        applyStimulus(1'b1, 1'b0, FMT_HALF, 32'h1001_0008, 32'h0000_1234, 1'b0);
        checkOutput("sub_wr_keeps_data", dataMain, 32'hDEAD_BEEF);
        readAll(FMT_WORD, 32'h1001_0008, 32'h00AB_1234, "merge");
        readAll(FMT_BYTE, 32'h1001_000A, 32'h0000_00AB, "byte_rd");
        readAll(FMT_HALF, 32'h1001_000A, 32'h0000_00AB, "half_rd");
        readAll(FMT_BYTE, 32'h1001_0009, 32'h0000_0012, "byte_rd_l1");

        // Rejections; dmem_data must still show the last completed read.
        rejectReq(1'b1, 1'b0, FMT_WORD, 32'h1001_0006, 32'h0000_0012, "rej_word_mis");
        rejectReq(1'b1, 1'b0, FMT_HALF, 32'h1001_0009, 32'h0000_0012, "rej_half_mis");
        rejectReq(1'b1, 1'b0, FMT_WORD, 32'h1001_2000, 32'h0000_0012, "rej_range");
        rejectReq(1'b1, 1'b1, FMT_WORD, 32'h1001_0004, 32'h0000_0012, "rej_rw");
        rejectReq(1'b1, 1'b0, FMT_RSVD, 32'h1001_0004, 32'h0000_0012, "rej_rsvd");
        rejectReq(1'b1, 1'b0, FMT_WORD, 32'h1000_FFFC, 32'h0000_0012, "rej_below");
        readAll(FMT_WORD, 32'h1001_0004, 32'hDEAD_BEEF, "rej_keep4");
        readAll(FMT_WORD, 32'h1001_0008, 32'h00AB_1234, "rej_keep8");

        // Last word in range is accepted.
        applyStimulus(1'b1, 1'b0, FMT_WORD, 32'h1001_1FFC, 32'hA5A5_5A5A, 1'b0);
        checkOutput("top_wr_low", 32'(lowMain), 32'd2);
        readAll(FMT_WORD, 32'h1001_1FFC, 32'hA5A5_5A5A, "top_word");

        // Inputs changed while BUSY must not disturb the latched access.
        applyStimulus(1'b1, 1'b0, FMT_WORD, 32'h1001_0010, 32'hCAFE_F00D, 1'b1);
        checkOutput("scr_low_w5", 32'(low5), 32'd6);
        applyStimulus(1'b0, 1'b1, FMT_WORD, 32'h1001_0010, 32'h0, 1'b1);
        checkOutput("scr_rd", dataMain, 32'hCAFE_F00D);
        checkOutput("scr_rd_w0", data0, 32'hCAFE_F00D);
        checkOutput("scr_rd_w5", data5, 32'hCAFE_F00D);

        // Reset during a write aborts it before commit.
        applyStimulus(1'b1, 1'b0, FMT_WORD, 32'h1001_000C, 32'h1111_1111, 1'b0);
        readAll(FMT_WORD, 32'h1001_000C, 32'h1111_1111, "pre_rst");
        @(negedge clk);
        dmemW    = 1'b1;
        storeFmt = FMT_WORD;
        dataAddr = 32'h1001_000C;
        wData    = 32'h5555_5555;
        @(posedge clk);
        @(negedge clk);
        dmemW = 1'b0;
        checkOutput("mid_busy", 32'(readyMain), 32'd0);
        #1 rst = 1'b0;
        #1;
        checkOutput("abort_ready", 32'(readyMain && ready0 && ready5), 32'd1);
        checkOutput("abort_data", dataMain, 32'h0);
        checkOutput("abort_data_w5", data5, 32'h0);
        checkOutput("abort_err", 32'(errMain), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        readAll(FMT_WORD, 32'h1001_000C, 32'h1111_1111, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
